// File: rtl/alu_arbiter_if.sv
// Requester-side bundle for alu_arbiter: two request channels
// (valid/ready/a/b/ctrl) and two response channels (valid/ready/result/flags).
interface alu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [CTRL_W-1:0] req0_ctrl;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [CTRL_W-1:0] req1_ctrl;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_result;
  logic              rsp0_zero;
  logic              rsp0_less;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_result;
  logic              rsp1_zero;
  logic              rsp1_less;

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl,
    output req1_valid, req1_a, req1_b, req1_ctrl,
    input  req0_ready, req1_ready,
    output rsp0_ready, rsp1_ready,
    input  rsp0_valid, rsp0_result, rsp0_zero, rsp0_less,
    input  rsp1_valid, rsp1_result, rsp1_zero, rsp1_less
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl,
    input  req1_valid, req1_a, req1_b, req1_ctrl,
    output req0_ready, req1_ready,
    input  rsp0_ready, rsp1_ready,
    output rsp0_valid, rsp0_result, rsp0_zero, rsp0_less,
    output rsp1_valid, rsp1_result, rsp1_zero, rsp1_less
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter for the shared RV32I ALU with per-requester response regs.
// Ports: clk, rst_n (async low); bus (alu_arbiter_if.slave: req0/1, rsp0/1);
//   alu_a/alu_b/alu_ctrl drive the ALU, alu_result/alu_zero/alu_less come back.
// Build option: define ALU_ARB_RR_EN for round-robin ties (default: req0 wins).
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_arbiter_if.slave      bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_less
);

  typedef enum logic {LAST0, LAST1} last_t;

  last_t last_q, last_d;
  logic  elig0, elig1;
  logic  gnt0, gnt1;
  logic  ill0, ill1;

  function automatic logic illegal(input logic [CTRL_W-1:0] c);
    logic [3:0] c4;
    c4 = 4'(c);
    return c4 inside {4'b0101, 4'b0110, 4'b1100,
                      4'b1101, 4'b1110, 4'b1111};
  endfunction

  assign ill0 = illegal(bus.req0_ctrl);
  assign ill1 = illegal(bus.req1_ctrl);

  // A full response slot still accepts when it drains this cycle.
  // Gating with rst_n keeps ready low for the whole reset pulse.
  assign elig0 = rst_n && bus.req0_valid
              && (!bus.rsp0_valid || bus.rsp0_ready);
  assign elig1 = rst_n && bus.req1_valid
              && (!bus.rsp1_valid || bus.rsp1_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= LAST1;
    else        last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    if (gnt0)      last_d = LAST0;
    else if (gnt1) last_d = LAST1;
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case ({elig1, elig0})
      2'b01: gnt0 = 1'b1;
      2'b10: gnt1 = 1'b1;
      2'b11: begin
`ifdef ALU_ARB_RR_EN
        gnt0 = (last_q == LAST1);
        gnt1 = (last_q == LAST0);
`else
        gnt0 = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = '0;
    unique case (1'b1)
      gnt0 && !ill0: begin
        alu_a    = bus.req0_a;
        alu_b    = bus.req0_b;
        alu_ctrl = bus.req0_ctrl;
      end
      gnt1 && !ill1: begin
        alu_a    = bus.req1_a;
        alu_b    = bus.req1_b;
        alu_ctrl = bus.req1_ctrl;
      end
      default: ;
    endcase
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  // Illegal codes capture a fixed 0 / zero=1 / less=0, whatever the ALU says.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp0_valid  <= 1'b0;
      bus.rsp0_result <= '0;
      bus.rsp0_zero   <= 1'b0;
      bus.rsp0_less   <= 1'b0;
    end else if (gnt0) begin
      bus.rsp0_valid  <= 1'b1;
      bus.rsp0_result <= ill0 ? '0 : alu_result;
      bus.rsp0_zero   <= ill0 ? 1'b1 : alu_zero;
      bus.rsp0_less   <= ill0 ? 1'b0 : alu_less;
    end else if (bus.rsp0_ready) begin
      bus.rsp0_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp1_valid  <= 1'b0;
      bus.rsp1_result <= '0;
      bus.rsp1_zero   <= 1'b0;
      bus.rsp1_less   <= 1'b0;
    end else if (gnt1) begin
      bus.rsp1_valid  <= 1'b1;
      bus.rsp1_result <= ill1 ? '0 : alu_result;
      bus.rsp1_zero   <= ill1 ? 1'b1 : alu_zero;
      bus.rsp1_less   <= ill1 ? 1'b0 : alu_less;
    end else if (bus.rsp1_ready) begin
      bus.rsp1_valid  <= 1'b0;
    end
  end

endmodule
